// File: rtl/pll_lock_supervisor.sv
// Purpose: PLL bring-up supervisor. It pulses pll_rst, waits for lock with a timeout and
//   bounded retries, and qualifies lock stability before releasing sys_reset.
// Latency: sys_reset falls LOCK_STABLE_CYC+3 cycles after locked rises (2-FF sync + 1 detect).
//   All outputs are registered.
// Backpressure: none; runs freely on inclk0. Build with PLL_LOCK_SUPERVISOR_DEGLITCH_EN to filter RUN lock-loss.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYC    = 32,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRY        = 7
) (
    input  logic       inclk0,
    input  logic       areset,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       pll_ok,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);
    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_CNT = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
    localparam int TW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    // Terminal timer values: the transition fires on the edge where the timer reads N-1.
    localparam logic [TW-1:0] RST_LAST     = TW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYC - 1);
    localparam logic [2:0]    RETRY_LIMIT  = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          lock_meta_q, locked_s_q;
    logic [2:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_reset_q, sys_reset_d;
    logic          pll_ok_q, pll_ok_d;
    logic          fail_q, fail_d;
    logic          lock_lost;

    // Two-flop synchronizer for the asynchronous locked input.
    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            lock_meta_q <= 1'b0;
            locked_s_q  <= 1'b0;
        end else begin
            lock_meta_q <= locked;
            locked_s_q  <= lock_meta_q;
        end
    end

`ifdef PLL_LOCK_SUPERVISOR_DEGLITCH_EN
    logic [1:0] low_q, low_d;

    // Count consecutive low samples while running; the fourth one in a row is a real loss.
    always_comb begin
        low_d = 2'd0;
        if (state_q == S_RUN && !locked_s_q && low_q != 2'd3) begin
            low_d = low_q + 2'd1;
        end
    end

    // Low-run counter register.
    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            low_q <= 2'd0;
        end else begin
            low_q <= low_d;
        end
    end

    assign lock_lost = (state_q == S_RUN) && !locked_s_q && (low_q == 2'd3);
`else
    assign lock_lost = (state_q == S_RUN) && !locked_s_q;
`endif

    // Next state, counters and registered-output values derived from the next state.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            S_RESET_PLL: begin
                if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock is checked first so it wins over a coincident timeout.
                if (locked_s_q) begin
                    state_d = S_STABILIZE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + 3'd1;
                        state_d = S_RESET_PLL;
                    end
                end
            end
            S_STABILIZE: begin
                if (!locked_s_q) state_d = S_WAIT_LOCK;
                else if (timer_q == STABLE_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (lock_lost) begin
                    state_d = S_RESET_PLL;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            S_FAIL: state_d = S_FAIL;
            default: state_d = S_RESET_PLL;
        endcase

        if (state_d == S_RUN) retry_d = 3'd0;

        // Timer restarts on every state change and idles where no timing is needed.
        if (state_d != state_q || state_q == S_RUN || state_q == S_FAIL) timer_d = '0;
        else timer_d = timer_q + TW'(1);

        pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        sys_reset_d = (state_d != S_RUN);
        pll_ok_d    = (state_d == S_RUN);
        fail_d      = (state_d == S_FAIL);
    end

    // State, timer, counters and output registers.
    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            state_q     <= S_RESET_PLL;
            timer_q     <= '0;
            retry_q     <= 3'd0;
            loss_q      <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            pll_ok_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            pll_ok_q    <= pll_ok_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_reset     = sys_reset_q;
    assign pll_ok        = pll_ok_q;
    assign fail          = fail_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule
